// File: rtl/frame_composer.sv
// -----------------------------------------------------------------------------
// frame_composer
//
// Renders the pong game state (ball + two paddles) into a double-buffered
// 16x16 bitmap for the LED matrix scan driver. Game state is snapshotted
// once per frame and composed row by row into the back bank. The banks are
// exchanged only on a scan-frame boundary (frame_start), so a scan never
// shows a half-drawn frame.
//
// Parameters:
//   PADDLE_COL_L  column of the left paddle (0..15)
//   PADDLE_COL_R  column of the right paddle (0..15)
//   MIRROR        1 = bit-reverse row_data (column c driven on bit 15-c)
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   x, y         ball column / row
//   paddle_l     left paddle bitmap, bit r = row r lit
//   paddle_r     right paddle bitmap, bit r = row r lit
//   frame_start  one-cycle pulse at the start of a matrix scan
//   row_req      read request for row row_addr
//   row_addr     row to read (0..15)
//   row_valid    row_data valid (registered)
//   row_data     front-buffer row, bit c = column c (before MIRROR)
//   swapped      one-cycle pulse in the cycle after the bank exchange
//
// Read handshake: row_req has no back-pressure. A request sampled high at a
// clk edge produces row_valid=1 with row_data = front[row_addr] after that
// same edge (latency 1, one row per cycle). When no request is sampled,
// row_valid drops to 0 and row_data keeps its previous value.
// -----------------------------------------------------------------------------
module frame_composer #(
    parameter int PADDLE_COL_L = 0,
    parameter int PADDLE_COL_R = 15,
    parameter bit MIRROR       = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  x,
    input  logic [3:0]  y,
    input  logic [15:0] paddle_l,
    input  logic [15:0] paddle_r,
    input  logic        frame_start,
    input  logic        row_req,
    input  logic [3:0]  row_addr,
    output logic        row_valid,
    output logic [15:0] row_data,
    output logic        swapped
);

    typedef enum logic [1:0] {
        SNAP    = 2'd0,
        COMPOSE = 2'd1,
        PENDING = 2'd2
    } state_t;

    // state is kept as a named signal so checkers can bind to it.
    state_t      state;
    state_t      state_nxt;
    logic        snap_en;
    logic        compose_en;
    logic        swap_en;

    logic [3:0]  rc;
    logic [3:0]  x_s;
    logic [3:0]  y_s;
    logic [15:0] paddle_l_s;
    logic [15:0] paddle_r_s;

    logic [15:0] bank0 [16];
    logic [15:0] bank1 [16];
    logic        sel;            // index of the front bank

    logic [15:0] compose_row;
    logic [15:0] front_row;
    logic [15:0] row_q;
    logic [15:0] row_rev;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SNAP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        snap_en    = 1'b0;
        compose_en = 1'b0;
        swap_en    = 1'b0;
        case (state)
            SNAP: begin
                snap_en   = 1'b1;
                state_nxt = COMPOSE;
            end
            COMPOSE: begin
                compose_en = 1'b1;
                if (rc == 4'd15) begin
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                // frame_start outside PENDING is dropped by construction.
                if (frame_start) begin
                    swap_en   = 1'b1;
                    state_nxt = SNAP;
                end
            end
            default: state_nxt = SNAP;
        endcase
    end

    // ---------------- snapshot / row counter ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rc         <= 4'd0;
            x_s        <= 4'd0;
            y_s        <= 4'd0;
            paddle_l_s <= 16'd0;
            paddle_r_s <= 16'd0;
        end else if (snap_en) begin
            rc         <= 4'd0;
            x_s        <= x;
            y_s        <= y;
            paddle_l_s <= paddle_l;
            paddle_r_s <= paddle_r;
        end else if (compose_en) begin
            rc <= rc + 4'd1;
        end
    end

    // Overlapping objects are OR'd, so coincident pixels simply merge.
    always_comb begin
        compose_row = ({15'd0, paddle_l_s[rc]} << PADDLE_COL_L)
                    | ({15'd0, paddle_r_s[rc]} << PADDLE_COL_R);
        if (y_s == rc) begin
            compose_row = compose_row | (16'd1 << x_s);
        end
    end

    // ---------------- banks ----------------
    // Only the back bank (!sel) is ever written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                bank0[i] <= 16'd0;
                bank1[i] <= 16'd0;
            end
        end else if (compose_en) begin
            if (sel) begin
                bank0[rc] <= compose_row;
            end else begin
                bank1[rc] <= compose_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel     <= 1'b0;
            swapped <= 1'b0;
        end else begin
            swapped <= swap_en;
            if (swap_en) begin
                sel <= ~sel;
            end
        end
    end

    // ---------------- read path ----------------
    // front_row uses the current sel, so a read sampled on the swap edge
    // still returns the old frame.
    assign front_row = sel ? bank1[row_addr] : bank0[row_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            row_valid <= 1'b0;
            row_q     <= 16'd0;
        end else begin
            row_valid <= row_req;
            if (row_req) begin
                row_q <= front_row;
            end
        end
    end

    always_comb begin
        row_rev = 16'd0;
        for (int c = 0; c < 16; c++) begin
            row_rev[c] = row_q[15-c];
        end
    end

    assign row_data = MIRROR ? row_rev : row_q;

endmodule
